// File: rtl/sync_link_pkg.sv
// sync_link_pkg: shared link constants (state encoding, line codes, receiver sync threshold)
package sync_link_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SYNC = 2'b01,
    ST_TAIL = 2'b10,
    ST_DATA = 2'b11
  } tx_state_e;
  localparam logic [9:0] SYNC_CODE = 10'b00000_11111;
  localparam logic [9:0] TAIL_CODE = 10'b10011_11100;
  localparam logic [9:0] IDLE_CODE = 10'b00000_00000;
  localparam int unsigned RX_SYNC_THRESHOLD = 30;
endpackage

// File: rtl/sync_burst_cnt.sv
// sync_burst_cnt: 8-bit sync word counter with clear/enable and terminal-count flag
module sync_burst_cnt #(
  parameter int unsigned COUNT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [7:0] cnt_q, cnt_d;
  // clear wins over increment so a restarted burst always begins at zero
  always_comb cnt_d = clr ? 8'd0 : en ? cnt_q + 8'd1 : cnt_q;
  // counter register
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign tc = cnt_q == 8'(COUNT - 1);
endmodule

// File: rtl/sync_frame_tx.sv
// sync_frame_tx: sync burst + tail + data framing for the uphole serializer; SYNC_TX_RESYNC_TIMER_EN adds a periodic auto-resync
module sync_frame_tx
  import sync_link_pkg::*;
#(
  parameter int unsigned SYNC_COUNT      = 32,
  parameter int unsigned RESYNC_INTERVAL = 4096
) (
  input  logic       UpSig_TClk,
  input  logic       Rst,
  input  logic       tx_en,
  input  logic       resync_req,
  input  logic [9:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic [9:0] UpSig_TOut,
  output logic       UpSig_TDen,
  output logic [1:0] tx_state,
  output logic       link_sent
);
  if (SYNC_COUNT <= RX_SYNC_THRESHOLD || SYNC_COUNT > 255) begin : g_bad_sync_count
    $error("SYNC_COUNT must be 31..255");
  end
  if (RESYNC_INTERVAL < 2 || RESYNC_INTERVAL > 65536) begin : g_bad_interval
    $error("RESYNC_INTERVAL must be 2..65536");
  end
  tx_state_e  state_q, state_d;
  logic       pend_q, pend_d;
  logic [9:0] out_q, out_d;
  logic       den_q, den_d;
  logic       accept, cnt_clr, cnt_en, cnt_tc, timer_hit;
`ifdef SYNC_TX_RESYNC_TIMER_EN
  logic [15:0] timer_q, timer_d;
  // data-phase cycle counter; restarts every time the data phase is re-entered
  always_comb begin
    timer_d   = state_q == ST_DATA ? timer_q + 16'd1 : 16'd0;
    timer_hit = state_q == ST_DATA && timer_q == 16'(RESYNC_INTERVAL - 1);
  end
  // timer register
  always_ff @(posedge UpSig_TClk or posedge Rst)
    if (Rst) timer_q <= '0;
    else timer_q <= timer_d;
`else
  assign timer_hit = 1'b0;
`endif
  sync_burst_cnt #(.COUNT(SYNC_COUNT)) u_cnt (
    .clk(UpSig_TClk),
    .rst(Rst),
    .clr(cnt_clr),
    .en (cnt_en),
    .tc (cnt_tc)
  );
  assign data_ready = state_q == ST_DATA && !pend_q && tx_en;
  // next state and next output word; the word is chosen from the next state so it lines up with tx_state
  always_comb begin
    accept  = data_valid && data_ready;
    state_d = !tx_en ? ST_IDLE :
              state_q == ST_IDLE ? ST_SYNC :
              state_q == ST_SYNC ? (resync_req ? ST_SYNC : cnt_tc ? ST_TAIL : ST_SYNC) :
              state_q == ST_TAIL ? (resync_req ? ST_SYNC : ST_DATA) :
              pend_q ? ST_SYNC : ST_DATA;
    pend_d  = tx_en && state_q == ST_DATA && !pend_q && (resync_req || timer_hit);
    cnt_clr = state_d == ST_SYNC && (state_q != ST_SYNC || resync_req);
    cnt_en  = state_q == ST_SYNC && !cnt_tc;
    out_d   = state_d == ST_SYNC ? SYNC_CODE :
              state_d == ST_TAIL ? TAIL_CODE :
              accept ? data_in : IDLE_CODE;
    den_d   = state_d != ST_IDLE;
  end
  // FSM and registered serializer outputs
  always_ff @(posedge UpSig_TClk or posedge Rst)
    if (Rst) begin
      state_q <= ST_IDLE;
      pend_q  <= 1'b0;
      out_q   <= IDLE_CODE;
      den_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
      den_q   <= den_d;
    end
  assign UpSig_TOut = out_q;
  assign UpSig_TDen = den_q;
  assign tx_state   = state_q;
  assign link_sent  = state_q == ST_DATA;
`ifndef SYNTHESIS
  // the source must keep line codes out of the data stream
  a_no_reserved: assert property (@(posedge UpSig_TClk) disable iff (Rst)
    accept |-> (data_in != SYNC_CODE && data_in != TAIL_CODE))
    else $error("reserved line code accepted on data_in");
`endif
endmodule

// File: tb/tb_sync_frame_tx.sv
// tb_sync_frame_tx: directed scoreboard bench for sync_frame_tx
module tb_sync_frame_tx;
  localparam logic [1:0] S_ID = 2'b00, S_SY = 2'b01, S_TL = 2'b10, S_DT = 2'b11;
  localparam logic [9:0] W_SY = 10'h01F, W_TL = 10'h27C, W_ID = 10'h000;
  logic       clk = 1'b0, rst = 1'b1;
  logic       tx_en = 1'b0, resync_req = 1'b0, data_valid = 1'b0;
  logic [9:0] data_in = '0;
  logic       data_ready, den, link;
  logic [9:0] tout;
  logic [1:0] st;
  typedef struct {
    logic [9:0] out;
    logic [1:0] st;
    logic       rdy;
  } exp_t;
  exp_t q[$];
  int checks = 0, fails = 0;
  always #5 clk = ~clk;
  sync_frame_tx #(.SYNC_COUNT(32), .RESYNC_INTERVAL(16)) dut (
    .UpSig_TClk(clk),
    .Rst       (rst),
    .tx_en     (tx_en),
    .resync_req(resync_req),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .UpSig_TOut(tout),
    .UpSig_TDen(den),
    .tx_state  (st),
    .link_sent (link)
  );
  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask
  // monitor: one expected entry per clock edge, compared just after the edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst && q.size() > 0) begin
      e = q.pop_front();
      chk("out", tout, e.out);
      chk("state", {8'd0, st}, {8'd0, e.st});
      chk("den", {9'd0, den}, {9'd0, e.st != S_ID});
      chk("link", {9'd0, link}, {9'd0, e.st == S_DT});
      chk("ready", {9'd0, data_ready}, {9'd0, e.rdy});
    end
  end
  task automatic cyc(input logic en, input logic rq, input logic v, input logic [9:0] d,
                     input logic [9:0] eo, input logic [1:0] es, input logic er);
    @(negedge clk);
    tx_en = en;
    resync_req = rq;
    data_valid = v;
    data_in = d;
    q.push_back('{eo, es, er});
  endtask
  task automatic burst(input int n, input logic v, input logic [9:0] d);
    for (int i = 0; i < n; i++) cyc(1, 0, v, d, W_SY, S_SY, 0);
    cyc(1, 0, v, d, W_TL, S_TL, 0);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_out"}, tout, W_ID);
    chk({tag, "_den"}, {9'd0, den}, 10'd0);
    chk({tag, "_state"}, {8'd0, st}, 10'd0);
    chk({tag, "_ready"}, {9'd0, data_ready}, 10'd0);
    chk({tag, "_link"}, {9'd0, link}, 10'd0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    // bring-up: 32 sync, 1 tail, then idle data phase
    burst(32, 0, 0);
    cyc(1, 0, 0, 0, W_ID, S_DT, 1);
    // single data word, then no valid
    cyc(1, 0, 1, 10'h155, 10'h155, S_DT, 1);
    cyc(1, 0, 0, 0, W_ID, S_DT, 1);
    // resync while streaming; held word goes out exactly once afterwards
    cyc(1, 1, 1, 10'h0AA, 10'h0AA, S_DT, 0);
    burst(32, 1, 10'h0AB);
    cyc(1, 0, 1, 10'h0AB, W_ID, S_DT, 1);
    cyc(1, 0, 1, 10'h0AB, 10'h0AB, S_DT, 1);
    cyc(1, 0, 0, 0, W_ID, S_DT, 1);
    // disable, resync ignored in idle, abort at sync word 10, full restart
    cyc(0, 0, 0, 0, W_ID, S_ID, 0);
    cyc(0, 1, 0, 0, W_ID, S_ID, 0);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, W_SY, S_SY, 0);
    cyc(0, 0, 0, 0, W_ID, S_ID, 0);
    burst(32, 0, 0);
    cyc(1, 0, 0, 0, W_ID, S_DT, 1);
    // resync during sync burst restarts the count
    cyc(0, 0, 0, 0, W_ID, S_ID, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, W_SY, S_SY, 0);
    cyc(1, 1, 0, 0, W_SY, S_SY, 0);
    burst(31, 0, 0);
    // resync during tail restarts the burst
    cyc(1, 1, 0, 0, W_SY, S_SY, 0);
    burst(31, 0, 0);
    cyc(1, 0, 0, 0, W_ID, S_DT, 1);
    // tx_en low with resync: disable wins, no leftover pending resync
    cyc(0, 1, 0, 0, W_ID, S_ID, 0);
    burst(32, 0, 0);
    cyc(1, 0, 0, 0, W_ID, S_DT, 1);
    cyc(1, 0, 0, 0, W_ID, S_DT, 1);
    cyc(1, 0, 1, 10'h155, 10'h155, S_DT, 1);
    // asynchronous reset mid-data
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_reset("async_rst");
    @(negedge clk);
    tx_en = 1'b0;
    data_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    burst(32, 0, 0);
    cyc(1, 0, 0, 0, W_ID, S_DT, 1);
`ifdef SYNC_TX_RESYNC_TIMER_EN
    for (int i = 0; i < 15; i++) cyc(1, 0, 0, 0, W_ID, S_DT, 1);
    cyc(1, 0, 0, 0, W_ID, S_DT, 0);
    burst(32, 0, 0);
    cyc(1, 0, 0, 0, W_ID, S_DT, 1);
`endif
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
